// File: rtl/cla_pkg.sv
// Shared types and sizing helpers for the sequential carry-lookahead adder.
package cla_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cla_state_t;

    localparam int CLA_SLICE_W = 2;

    function automatic int cla_steps(input int width);
        return width / CLA_SLICE_W;
    endfunction

    // Counter must be at least one bit even when a single step suffices.
    function automatic int cla_cnt_w(input int steps);
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/cla2_slice.sv
// Combinational 2-bit propagate/generate lookahead slice; shared with the full-width adder tile.
module cla2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] s,
    output logic       cout
);

    logic [1:0] p_s;
    logic [1:0] g_s;
    logic       c1_s;

    // Lookahead carries and sum bits for one 2-bit slice.
    always_comb begin
        p_s  = a ^ b;
        g_s  = a & b;
        c1_s = g_s[0] | (p_s[0] & cin);
        cout = g_s[1] | (p_s[1] & c1_s);
        s    = p_s ^ {c1_s, cin};
    end

endmodule

// File: rtl/cla_seq_ctrl.sv
// Multi-cycle adder: steps one 2-bit CLA slice across the operands, LSB pair first,
// with valid/ready handshakes on both sides.
module cla_seq_ctrl
    import cla_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int STEPS = cla_steps(WIDTH);
    localparam int CNT_W = cla_cnt_w(STEPS);

    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("cla_seq_ctrl: WIDTH must be even and >= 2");
    end

    cla_state_t       state_r, next_state_s;
    logic [WIDTH-1:0] a_sh_r, b_sh_r, sum_sh_r, sum_r;
    logic             c_r, cout_r, out_valid_r, busy_r;
    logic [CNT_W-1:0] step_r;
    logic             in_ready_s, accept_s, last_step_s;
    logic [1:0]       slice_s_s;
    logic             slice_co_s;
    logic [WIDTH+1:0] sum_cat_s;

    cla2_slice u_slice (
        .a    (a_sh_r[1:0]),
        .b    (b_sh_r[1:0]),
        .cin  (c_r),
        .s    (slice_s_s),
        .cout (slice_co_s)
    );

    assign last_step_s = (step_r == CNT_W'(STEPS - 1));
    assign accept_s    = in_ready_s & in_valid;
    // Concatenation keeps the shift-in expression legal even when WIDTH is 2.
    assign sum_cat_s   = {slice_s_s, sum_sh_r};

    // Next-state decode and the combinational in_ready.
    always_comb begin
        next_state_s = state_r;
        in_ready_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = ena;
                if (ena && in_valid) next_state_s = ST_RUN;
                else                 next_state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (ena && last_step_s) next_state_s = ST_DONE;
                else                    next_state_s = ST_RUN;
            end
            ST_DONE: begin
                if (ena && out_ready) next_state_s = ST_IDLE;
                else                  next_state_s = ST_DONE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register plus flop-driven status outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            out_valid_r <= (next_state_s == ST_DONE);
            busy_r      <= (next_state_s != ST_IDLE);
        end
    end

    // Operand/sum shift registers, carry feedback, step counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            sum_sh_r <= {WIDTH{1'b0}};
            sum_r    <= {WIDTH{1'b0}};
            c_r      <= 1'b0;
            cout_r   <= 1'b0;
            step_r   <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            c_r      <= cin;
            step_r   <= {CNT_W{1'b0}};
            sum_sh_r <= {WIDTH{1'b0}};
        end else if (ena && (state_r == ST_RUN)) begin
            sum_sh_r <= sum_cat_s[WIDTH+1:2];
            a_sh_r   <= a_sh_r >> CLA_SLICE_W;
            b_sh_r   <= b_sh_r >> CLA_SLICE_W;
            c_r      <= slice_co_s;
            step_r   <= step_r + CNT_W'(1);
            if (last_step_s) begin
                sum_r  <= sum_cat_s[WIDTH+1:2];
                cout_r <= slice_co_s;
            end else begin
                sum_r  <= sum_r;
                cout_r <= cout_r;
            end
        end else begin
            sum_r  <= sum_r;
            cout_r <= cout_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = sum_r;
    assign cout      = cout_r;

endmodule
